inject_port_buffer: RTL
=======================

# inject_port_buffer

Per-direction injection buffer between the local unit and one router inject port (xpos/ypos/zpos/xneg/yneg/zneg). Accepts flits from the local unit, queues them in a FIFO, and presents them to the router using the router's `inject_*_avail` signal as flow control. The local unit never has to hold a flit while the router is busy. Six instances sit inside each node, one per inject port.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO entries; must be a power of two, ≥ 4.
- `STALL_LIMIT`, 64 — consecutive blocked cycles before `stall` asserts; must be ≥ 1.

Ports:
- `clk` input 1 — single clock; all logic is on its rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `in_flit` input FLIT_SIZE — flit from the local unit.
- `in_valid` input 1 — `in_flit` is valid this cycle.
- `in_ready` output 1 — FIFO can accept; high when `count < DEPTH`.
- `out_flit` output FLIT_SIZE — drives the router's `inject_*`.
- `out_valid` output 1 — drives the router's `inject_*_valid`.
- `out_avail` input 1 — the router's `inject_*_avail`.
- `count` output $clog2(DEPTH)+1 — current occupancy, counting both the FIFO and the output register.
- `stall` output 1 — set when the head flit has been blocked ≥ `STALL_LIMIT` cycles.
- `dropped` output 16 — number of flits offered while `in_ready` was low; saturates at 0xFFFF.

## Operation
- **Accept.** A flit is accepted when `in_valid && in_ready`.
- **Drop.** When `in_valid && !in_ready`, the flit is discarded and `dropped` increments, saturating at 0xFFFF. There is no stall to the local unit.
- **Output register.** `out_flit`/`out_valid` are registered. The output FSM has two states:
  - OUT_EMPTY: `out_valid` = 0. When the FIFO is non-empty, or a flit is being accepted this cycle, load the register and go to OUT_FULL. A flit accepted while the FIFO is empty bypasses the FIFO and goes straight into the register.
  - OUT_FULL: `out_valid` = 1. When `out_avail` = 1 the flit is transferred. On transfer, reload from the FIFO head (or from the bypass) if one is available and stay in OUT_FULL; otherwise go to OUT_EMPTY.
- **Transfer.** A flit is transferred on any cycle with `out_valid && out_avail`. `out_flit` holds steady while `out_valid && !out_avail`.
- **Ordering.** Strict FIFO order. No flit is duplicated or reordered.
- **Capacity.** `count` covers the FIFO plus the output register, so `in_ready` = (`count < DEPTH`). Total capacity is DEPTH flits, i.e. the FIFO holds DEPTH-1.
- **Simultaneous events.** Accept and transfer in the same cycle leave `count` unchanged. With `count == DEPTH` and a transfer that cycle, `in_ready` is still 0: a same-cycle offer is dropped. There is no fall-through from transfer to ready.
- **Stall watchdog.** A counter increments on every cycle with `out_valid && !out_avail`. It clears on transfer or when the FSM is in OUT_EMPTY. `stall` = (counter ≥ `STALL_LIMIT`). The counter saturates, so `stall` stays set until the next transfer.
- **Reset values** (when `rst` = 0, any time):
  - FIFO pointers = 0, FSM = OUT_EMPTY.
  - `out_valid` = 0, `out_flit` = 0, `count` = 0.
  - `in_ready` = 1, `stall` = 0, `dropped` = 0.
  - A reset mid-operation discards all queued flits.

## Timing
- Latency from accept to `out_valid` is 1 cycle when the block is empty.
- Sustained throughput is 1 flit/cycle while `out_avail` stays high.
- `in_ready` and `count` are registered and reflect the state after the previous edge. There is no combinational path from `out_avail` to `in_ready`.
- `stall` rises on the edge that ends the `STALL_LIMIT`-th consecutive blocked cycle.
- Reset deassertion is synchronised inside the block, using a 2-flop release. The first accept can occur on the 2nd cycle after `rst` rises.

## Configuration
- `INJECT_STATS_EN` defined: two additional 32-bit saturating output ports are present.
  - `stat_accepted` — flits accepted.
  - `stat_sent` — flits transferred.
  - Both reset to 0.
- `INJECT_STATS_EN` undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package (alongside `FLIT_SIZE`):
  - `InjectDepth` default constant.
  - `InjectStallLimit` default constant.
  - `out_state_t` enum {OUT_EMPTY, OUT_FULL}.
- Sub-module `inject_fifo`:
  - Synchronous FIFO with `DEPTH-1` entries.
  - Ports: write enable, read enable, head data, empty, full.
  - Asynchronous active-low reset.
- The top level owns the output register, the bypass path, `count`, the watchdog and the drop counter.

## Test plan
- **Single flit.** After reset, offer one flit 0xA5 with `out_avail` = 1 → `out_valid` = 1 with 0xA5 exactly 1 cycle later, for 1 cycle; `count` returns to 0.
- **Fill and drop.** `DEPTH` = 16, `out_avail` = 0, offer 20 consecutive flits → first 16 accepted, `in_ready` = 0 after the 16th, `dropped` = 4, `count` = 16. Raise `out_avail` → flits emerge in order 0..15 on back-to-back cycles.
- **Streaming.** Stream 100 flits with `out_avail` = 1 throughout → 100 transfers in 100 consecutive cycles, `count` ≤ 1, `dropped` = 0.
- **Watchdog.** Hold one flit with `out_avail` = 0 for 64 cycles → `stall` = 1 after the 64th blocked cycle. Raise `out_avail` for 1 cycle → transfer occurs and `stall` = 0 on the next cycle.
- **Reset mid-operation.** With 5 flits queued, pulse `rst` low → `out_valid` = 0, `count` = 0 and `dropped` = 0 immediately; no stale flit appears after release.
- **Stats (with `INJECT_STATS_EN`).** Run the fill-and-drop scenario → `stat_accepted` = 16, `stat_sent` = 16 after the drain.

Source files
------------

// File: rtl/inject_port_buffer_pkg.sv
// inject_port_buffer_pkg: shared flit width, buffer defaults and output FSM states.
package inject_port_buffer_pkg;
  localparam int FLIT_SIZE = 32;
  localparam int InjectDepth = 16;
  localparam int InjectStallLimit = 64;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
endpackage

// File: rtl/inject_fifo.sv
// inject_fifo: DEPTH-1 entry synchronous FIFO feeding the inject output register.
module inject_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 2);
  localparam logic [PW-1:0] N = PW'(DEPTH - 1);
  logic [W-1:0] mem [DEPTH-1];
  logic [PW-1:0] wp, rp, cnt;
  assign empty = cnt == '0;
  assign full = cnt == N;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (rd) rp <= (rp == LAST) ? '0 : rp + 1'b1;
      cnt <= cnt + PW'(wr) - PW'(rd);
    end
endmodule

// File: rtl/inject_port_buffer.sv
// inject_port_buffer: FIFO + output register in front of one router inject port.
// Optional INJECT_STATS_EN adds saturating stat_accepted / stat_sent counters.
module inject_port_buffer
  import inject_port_buffer_pkg::*;
#(
  parameter int DEPTH = InjectDepth,
  parameter int STALL_LIMIT = InjectStallLimit
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_SIZE-1:0]   in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [FLIT_SIZE-1:0]   out_flit,
  output logic                   out_valid,
  input  logic                   out_avail,
  output logic [$clog2(DEPTH):0] count,
  output logic                   stall,
  output logic [15:0]            dropped
`ifdef INJECT_STATS_EN
  ,
  output logic [31:0]            stat_accepted,
  output logic [31:0]            stat_sent
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  localparam logic [SW-1:0] LIM = SW'(STALL_LIMIT);
  logic [1:0] sync;
  logic rst_n, accept, xfer, load, bypass, fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [FLIT_SIZE-1:0] head;
  logic [SW-1:0] wd;
  out_state_t state, state_nx;
  // assertion is immediate, release waits two clock edges
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= 2'b00;
    else sync <= {sync[0], 1'b1};
  assign rst_n = sync[1];
  assign in_ready = count < CAP;
  assign out_valid = state == OUT_FULL;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_avail;
  assign load = !out_valid || xfer;
  assign fifo_rd = load && !fifo_empty;
  assign bypass = load && fifo_empty && accept;
  assign fifo_wr = accept && !bypass && !fifo_full;
  assign stall = wd >= LIM;
  inject_fifo #(.DEPTH(DEPTH), .W(FLIT_SIZE)) u_fifo (
    .clk(clk), .rst(rst_n), .wr(fifo_wr), .rd(fifo_rd), .din(in_flit),
    .dout(head), .empty(fifo_empty), .full(fifo_full)
  );
  always_comb begin
    state_nx = load ? ((fifo_rd || bypass) ? OUT_FULL : OUT_EMPTY) : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= OUT_EMPTY;
      out_flit <= '0;
      count <= '0;
      wd <= '0;
      dropped <= '0;
    end else begin
      state <= state_nx;
      if (fifo_rd || bypass) out_flit <= fifo_rd ? head : in_flit;
      count <= count + CW'(accept) - CW'(xfer);
      wd <= load ? '0 : wd + SW'(!stall);
      dropped <= dropped + 16'(in_valid && !in_ready && dropped != 16'hFFFF);
    end
`ifdef INJECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_accepted <= '0;
      stat_sent <= '0;
    end else begin
      stat_accepted <= stat_accepted + 32'(accept && stat_accepted != '1);
      stat_sent <= stat_sent + 32'(xfer && stat_sent != '1);
    end
`endif
endmodule
